// File: rtl/hybrid_overlap_add.sv
// Overlap-add and polyphase frequency inversion after the windowed IMDCT.
// Each (ch, sb) block of 2*NLINE terms: first half summed with the store and emitted, second half stored.
module hybrid_overlap_add #(
    parameter int unsigned W      = 32,
    parameter int unsigned NSB    = 32,
    parameter int unsigned NLINE  = 18,
    parameter int unsigned NCH    = 2,
    parameter int unsigned INVERT = 1,
    localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned SBW   = (NSB > 1) ? $clog2(NSB) : 1,
    localparam int unsigned IW    = (NLINE > 1) ? $clog2(NLINE) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    output logic           busy,
    input  logic [W-1:0]   s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [W-1:0]   m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [CHW-1:0] m_ch,
    output logic [SBW-1:0] m_sb,
    output logic [IW-1:0]  m_idx,
    output logic           m_last,
    output logic           sat
);

    localparam int unsigned DEPTH = NCH * NSB * NLINE;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned KW    = $clog2(2 * NLINE);

    localparam logic [KW-1:0]  KHALF   = KW'(NLINE);
    localparam logic [KW-1:0]  KLAST   = KW'(2 * NLINE - 1);
    localparam logic [KW-1:0]  KOUTEND = KW'(NLINE - 1);
    localparam logic [SBW-1:0] SBLAST  = SBW'(NSB - 1);
    localparam logic [CHW-1:0] CHLAST  = CHW'(NCH - 1);
    localparam logic [AW-1:0]  CLRLAST = AW'(DEPTH - 1);
    localparam logic [W-1:0]   MAXV    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   MINV    = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {StClear, StRun} state_e;

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [SBW-1:0] sb_q, sb_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [AW-1:0]  clr_q, clr_d;

    logic           we;
    logic [AW-1:0]  wa, ra;
    logic [W-1:0]   wd, rd_q;
    logic [KW-1:0]  rd_k;
    logic           first_half, accept;

    logic [W:0]     sum;
    logic           ovf, res_sat;
    logic [W-1:0]   clamped, res;

    logic [W-1:0]   m_data_q;
    logic           m_valid_q, m_last_q, sat_q;
    logic [CHW-1:0] m_ch_q;
    logic [SBW-1:0] m_sb_q;
    logic [IW-1:0]  m_idx_q;

    logic [W-1:0]   mem [DEPTH];

    function automatic logic [AW-1:0] addr_of(logic [CHW-1:0] c, logic [SBW-1:0] s,
                                              logic [KW-1:0] i);
        return AW'((int'(c) * NSB + int'(s)) * NLINE + int'(i));
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        sb_d       = sb_q;
        ch_d       = ch_q;
        clr_d      = clr_q;
        we         = 1'b0;
        wa         = clr_q;
        wd         = '0;
        first_half = (k_q < KHALF);
        busy       = (state_q == StClear);
        s_ready    = (state_q == StRun) && (!first_half || !m_valid_q || m_ready);
        accept     = s_valid && s_ready && !flush;

        case (state_q)
            StClear: begin
                we = 1'b1;
                if (flush) begin
                    clr_d = '0;
                end else if (clr_q == CLRLAST) begin
                    clr_d   = '0;
                    state_d = StRun;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StClear;
                    k_d     = '0;
                    sb_d    = '0;
                    ch_d    = '0;
                    clr_d   = '0;
                end else if (accept) begin
                    if (!first_half) begin
                        we = 1'b1;
                        wa = addr_of(ch_q, sb_q, k_q - KHALF);
                        wd = s_data;
                    end
                    if (k_q == KLAST) begin
                        k_d = '0;
                        if (sb_q == SBLAST) begin
                            sb_d = '0;
                            ch_d = (ch_q == CHLAST) ? '0 : ch_q + 1'b1;
                        end else begin
                            sb_d = sb_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase

        // Prefetch from the next position so a first-half term never waits on the RAM.
        rd_k = (k_d < KHALF) ? k_d : k_d - KHALF;
        ra   = addr_of(ch_d, sb_d, rd_k);
    end

    always_comb begin
        sum     = {s_data[W-1], s_data} + {rd_q[W-1], rd_q};
        ovf     = sum[W] ^ sum[W-1];
        clamped = ovf ? (sum[W] ? MINV : MAXV) : sum[W-1:0];
        res     = clamped;
        res_sat = ovf;
        if ((INVERT != 0) && sb_q[0] && k_q[0]) begin
            if (clamped == MINV) begin
                res     = MAXV;
                res_sat = 1'b1;
            end else begin
                res = '0 - clamped;
            end
        end
    end

    // Read-first RAM: a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_q <= mem[ra];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            k_q     <= '0;
            sb_q    <= '0;
            ch_q    <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sb_q    <= sb_d;
            ch_q    <= ch_d;
            clr_q   <= clr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            m_sb_q    <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
            sat_q     <= 1'b0;
        end else if (flush) begin
            m_valid_q <= 1'b0;
        end else if (accept && first_half) begin
            m_valid_q <= 1'b1;
            m_data_q  <= res;
            m_ch_q    <= ch_q;
            m_sb_q    <= sb_q;
            m_idx_q   <= k_q[IW-1:0];
            m_last_q  <= (ch_q == CHLAST) && (sb_q == SBLAST) && (k_q == KOUTEND);
            sat_q     <= res_sat;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;
    assign m_sb    = m_sb_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;
    assign sat     = sat_q && m_valid_q;

endmodule

// File: tb/tb_hybrid_overlap_add.sv
// Directed bench for hybrid_overlap_add: clear timing, overlap sums, inversion,
// saturation, backpressure ordering and flush.
module tb_hybrid_overlap_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        m_ready;
    logic        busy, s_ready, m_valid, m_last, sat;
    logic [31:0] m_data;
    logic [0:0]  m_ch;
    logic [4:0]  m_sb, m_idx;
    logic        n_busy, n_s_ready, n_m_valid, n_m_last, n_sat;
    logic [31:0] n_m_data;
    logic [0:0]  n_m_ch;
    logic [4:0]  n_m_sb, n_m_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    bit bp_en = 1'b0;

    typedef struct {
        logic [31:0] d, nd;
        logic [10:0] tag, ntag;
        logic        last, nlast, sat, nsat;
    } out_t;

    out_t q[$];
    out_t e;

    hybrid_overlap_add u_dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_ch(m_ch), .m_sb(m_sb), .m_idx(m_idx), .m_last(m_last), .sat(sat)
    );

    hybrid_overlap_add #(.INVERT(0)) u_noinv (
        .clk(clk), .rst(rst), .flush(flush), .busy(n_busy),
        .s_data(s_data), .s_valid(s_valid), .s_ready(n_s_ready),
        .m_data(n_m_data), .m_valid(n_m_valid), .m_ready(m_ready),
        .m_ch(n_m_ch), .m_sb(n_m_sb), .m_idx(n_m_idx), .m_last(n_m_last), .sat(n_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            e.d     = m_data;
            e.nd    = n_m_data;
            e.tag   = {m_ch, m_sb, m_idx};
            e.ntag  = {n_m_ch, n_m_sb, n_m_idx};
            e.last  = m_last;
            e.nlast = n_m_last;
            e.sat   = sat;
            e.nsat  = n_sat;
            q.push_back(e);
        end
        if (s_valid && s_ready && !flush) acc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] tag_of(int ch, int sb, int idx);
        return {1'(ch), 5'(sb), 5'(idx)};
    endfunction

    function automatic logic [31:0] gen(int g, int ch, int sb, int k);
        case (g)
            1: begin
                if (ch == 0 && sb == 0) return 32'h1000_0000;
                if (ch == 0 && sb == 1) return (k < 18) ? 32'h2000_0000 : 32'h0;
                if (ch == 0 && sb == 2 && k == 18) return 32'h7FFF_FFF0;
                if (ch == 0 && sb == 2 && k == 19) return 32'h8000_0000;
                return 32'h0;
            end
            2: begin
                if (ch == 0 && sb == 0 && k < 18) return 32'h0800_0000;
                if (ch == 0 && sb == 2 && k == 0) return 32'h0000_0100;
                if (ch == 0 && sb == 2 && k == 1) return 32'h8000_0000;
                return 32'h0;
            end
            3: return (k < 18) ? 32'((ch << 16) | (sb << 8) | (k + 1)) : 32'h0;
            4: return (k < 18) ? 32'h0 : 32'h0100_0000;
            5: return (k < 18) ? 32'h0030_0000 + 32'(k) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench aborted on timeout");
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("send timeout", 32'(n), 32'd0);
            finish_now();
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_granule(input int g);
        for (int ch = 0; ch < 2; ch++)
            for (int sb = 0; sb < 32; sb++)
                for (int k = 0; k < 36; k++) send(gen(g, ch, sb, k));
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n), 32'd1152);
    endtask

    initial begin
        int start_cyc, start_acc, n;
        logic [31:0] v, exp_d;
        logic exp_s;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy/ready/valid", {busy, s_ready, m_valid}, 32'b100);
        check("reset data", m_data, 32'h0);
        check("reset tags", {m_ch, m_sb, m_idx, m_last, sat}, 32'h0);
        check("reset noinv", {n_busy, n_s_ready, n_m_valid}, 32'b100);
        rst = 1'b0;
        wait_clear("reset clear cycles");
        check("run ready/valid", {busy, s_ready, m_valid}, 32'b010);

        // Granule 1: empty store, inversion on sb1, preload saturation words in sb2.
        q.delete();
        send_granule(1);
        repeat (2) @(posedge clk);
        #1;
        check("g1 count", 32'(q.size()), 32'd1152);
        if (q.size() == 1152) begin
            for (int i = 0; i < 18; i++) begin
                check($sformatf("g1 sb0 data %0d", i), q[i].d, 32'h1000_0000);
                check($sformatf("g1 sb0 tag %0d", i), 32'(q[i].tag), 32'(tag_of(0, 0, i)));
                exp_d = i[0] ? 32'hE000_0000 : 32'h2000_0000;
                check($sformatf("g1 sb1 data %0d", i), q[18+i].d, exp_d);
                check($sformatf("g1 sb1 noinv %0d", i), q[18+i].nd, 32'h2000_0000);
                check($sformatf("g1 sb1 noinv tag %0d", i),
                      {q[18+i].ntag, q[18+i].nlast, q[18+i].nsat},
                      {tag_of(0, 1, i), 2'b00});
            end
            check("g1 last flag", 32'(q[1151].last), 32'd1);
        end

        // Granule 2 at full rate: overlap sums and both saturation rails.
        q.delete();
        start_cyc = cyc;
        start_acc = acc;
        send_granule(2);
        check("g2 cycles", 32'(cyc - start_cyc), 32'd2304);
        check("g2 accepted", 32'(acc - start_acc), 32'd2304);
        repeat (2) @(posedge clk);
        #1;
        check("g2 count", 32'(q.size()), 32'd1152);
        if (q.size() == 1152) begin
            for (int i = 0; i < 1152; i++) begin
                exp_d = 32'h0;
                exp_s = 1'b0;
                if (i < 18) exp_d = 32'h1800_0000;
                if (i == 36) begin exp_d = 32'h7FFF_FFFF; exp_s = 1'b1; end
                if (i == 37) begin exp_d = 32'h8000_0000; exp_s = 1'b1; end
                check($sformatf("g2 data %0d", i), q[i].d, exp_d);
                check($sformatf("g2 sat %0d", i), 32'(q[i].sat), 32'(exp_s));
            end
        end

        // Granule 3 under random backpressure: order, tags, m_last, inversion.
        q.delete();
        bp_en = 1'b1;
        send_granule(3);
        n = 0;
        while (q.size() < 1152 && n < 200) begin
            @(posedge clk);
            n++;
        end
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("g3 count", 32'(q.size()), 32'd1152);
        if (q.size() == 1152) begin
            for (int i = 0; i < 1152; i++) begin
                int ch, sb, idx;
                ch  = i / 576;
                sb  = (i / 18) % 32;
                idx = i % 18;
                v   = 32'((ch << 16) | (sb << 8) | (idx + 1));
                exp_d = (sb[0] && idx[0]) ? 32'h0 - v : v;
                check($sformatf("g3 data %0d", i), q[i].d, exp_d);
                check($sformatf("g3 tag %0d", i), {q[i].tag, q[i].last, q[i].sat},
                      {tag_of(ch, sb, idx), (i == 1151), 1'b0});
            end
        end

        // Granule 4: dirty the store, then flush mid-block at ch0 sb5 k=10.
        q.delete();
        for (int sb = 0; sb < 5; sb++)
            for (int k = 0; k < 36; k++) send(gen(4, 0, sb, k));
        for (int k = 0; k < 10; k++) send(gen(4, 0, 5, k));
        start_acc = acc;
        s_data  = 32'hDEAD_BEEF;
        s_valid = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush drops valid", {m_valid, busy}, 32'b01);
        check("flush discards input", 32'(acc - start_acc), 32'd0);
        check("g4 count", 32'(q.size()), 32'd100);
        wait_clear("flush clear cycles");

        // Granule 5 after flush: zero store, counters back at ch0 sb0.
        q.delete();
        for (int k = 0; k < 36; k++) send(gen(5, 0, 0, k));
        repeat (2) @(posedge clk);
        #1;
        check("g5 count", 32'(q.size()), 32'd18);
        if (q.size() == 18) begin
            for (int i = 0; i < 18; i++) begin
                check($sformatf("g5 data %0d", i), q[i].d, 32'h0030_0000 + 32'(i));
                check($sformatf("g5 tag %0d", i), 32'(q[i].tag), 32'(tag_of(0, 0, i)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hybrid_overlap_add.md
Name: hybrid_overlap_add

Overview:
- Parametrised overlap-add / frequency-inversion stage that follows the windowed IMDCT in the MP3 hybrid synthesis path.
- Consumes a stream of 2*NLINE windowed IMDCT terms per (channel, subband) block.
- First half: adds each term to the overlap store and emits it. Second half: overwrites the store.
- Supports NCH channels, handles backpressure, saturates sums, and applies polyphase frequency inversion before the synthesis filterbank.

Parameters:
- W, 32, signed Q2.30 sample width for input, store and output.
- NSB, 32, subbands per granule per channel.
- NLINE, 18, output samples per block; each input block is 2*NLINE terms.
- NCH, 2, channel count; granule order is channel-major (ch0 sb0..NSB-1, then ch1 ...).
- INVERT, 1, enables frequency inversion when 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  one-cycle pulse: abort current granule, zero the overlap store
- busy  out  1  high while clearing the store
- s_data  in  W  signed windowed IMDCT term
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- m_data  out  W  signed time-domain sample
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_ch  out  $clog2(NCH) or 1  channel of m_data
- m_sb  out  $clog2(NSB)  subband of m_data
- m_idx  out  $clog2(NLINE)  sample index 0..NLINE-1
- m_last  out  1  last sample of granule (ch=NCH-1, sb=NSB-1, idx=NLINE-1)
- sat  out  1  high with m_valid when m_data was clamped

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset values: m_valid=0, m_data=0, m_ch/m_sb/m_idx=0, m_last=0, sat=0, s_ready=0, busy=1. Counters zero; state=CLEAR.
- Overlap store: NCH*NSB*NLINE words, single-port-per-role RAM with 1-cycle synchronous read.
- States: CLEAR and RUN.
- CLEAR: write 0 to every store address, one per cycle, for exactly NCH*NSB*NLINE cycles. busy=1 and s_ready=0 throughout. Then go to RUN with busy=0.
- RUN counters: k (0..2*NLINE-1), sb, ch. They advance on each accepted input (s_valid&&s_ready) and wrap k→sb→ch→0.
- First half, k<NLINE:
  - sum = s_data + store[ch][sb][k], computed at W+1 bits, then clamped to [-2^(W-1), 2^(W-1)-1]. sat=1 iff the clamp was active.
  - If INVERT, sb odd and k odd, the output is the negation of the clamped sum. Negating -2^(W-1) yields 2^(W-1)-1 with sat=1.
  - The result is registered to m_data with m_ch/m_sb/m_idx=k. Latency is 1 cycle from acceptance to m_valid.
- Second half, k>=NLINE: store[ch][sb][k-NLINE] <= s_data raw, no output produced.
- Store read prefetch: the store read address is driven from the next (ch,sb,k) so the first-half term arrives with no bubble. Sustained throughput is 1 input/cycle when m_ready=1.
- s_ready in RUN is 1 when k>=NLINE, else (!m_valid || m_ready). m_data and its tags are held stable while m_valid && !m_ready.
- Read/write ordering: within a block, first-half reads of index k precede the second-half write of k. The store is read-first, so a simultaneous read/write to the same address returns old data.
- flush in RUN: drops m_valid the next cycle, discards the partial block, zeros the counters and enters CLEAR. flush during CLEAR restarts the clear from address 0.
- flush coincident with an input handshake: flush wins and the input is discarded.
- rst mid-operation aborts everything. Store contents are cleared by the subsequent CLEAR pass.

Test Plan:
- Reset: deassert rst -> busy=1 for exactly 1152 cycles (defaults), s_ready=0, then busy=0, s_ready=1, m_valid=0.
- First granule: feed ch0 sb0 with k=0..35 all 0x10000000 -> 18 outputs of 0x10000000 (store was zero), idx 0..17. Second granule, same block with 0x08000000 -> outputs 0x18000000.
- Inversion: sb=1 first granule terms 0x20000000 -> odd idx outputs 0xE0000000, even idx 0x20000000. With INVERT=0 all are 0x20000000.
- Saturation: store 0x7FFFFFF0 then input 0x00000100 -> m_data=0x7FFFFFFF, sat=1. Store 0x80000000 + 0x80000000 -> 0x80000000, sat=1.
- Backpressure: m_ready toggled randomly during a full 2-channel granule -> 1152 outputs in order, no loss or duplicates, m_last only on ch1 sb31 idx17. With m_ready=1, 2304 inputs accepted in 2304 cycles.
- Flush mid-granule: flush at ch0 sb5 k=10 -> m_valid=0 next cycle, busy=1 for 1152 cycles. The next granule outputs equal the raw inputs (store zero).
